// File: rtl/ex_if.sv
// EX stage bus: ID/EX operands and controls in, EX/MEM results and the stall request out.
interface ex_if;
  logic [4:0]  rd;
  logic        regwe;
  logic [4:0]  aluop;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  rd_o;
  logic        regwe_o;
  logic [31:0] result;
  logic        stall_req;

  modport master (
    output rd, regwe, aluop, op1, op2, stall, flush,
    input  rd_o, regwe_o, result, stall_req
  );

  modport slave (
    input  rd, regwe, aluop, op1, op2, stall, flush,
    output rd_o, regwe_o, result, stall_req
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU and multiplier, plus a 32-cycle radix-2
// restoring divider that holds the front of the pipeline through stall_req.
module ex_stage (
  input logic clk,
  input logic rst,
  ex_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 6;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   dividend_q, dividend_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic              is_rem_q, is_rem_d;

  logic [4:0]        shamt;
  logic [2*XLEN-1:0] prod_ss, prod_su, prod_uu;
  logic [XLEN-1:0]   alu_res;
  logic              is_div, div_signed, div_rem, div_zero, div_ovf;
  logic [XLEN-1:0]   op1_abs, op2_abs, special_res, div_res, result_c;
  logic [XLEN:0]     rem_shift;
  logic [XLEN+1:0]   trial;
  logic              busy_req;
  logic              unused_bits;

  assign shamt   = bus.op2[4:0];
  assign prod_ss = {{XLEN{bus.op1[XLEN-1]}}, bus.op1} * {{XLEN{bus.op2[XLEN-1]}}, bus.op2};
  assign prod_su = {{XLEN{bus.op1[XLEN-1]}}, bus.op1} * {{XLEN{1'b0}}, bus.op2};
  assign prod_uu = {{XLEN{1'b0}}, bus.op1} * {{XLEN{1'b0}}, bus.op2};

  // Combinational ALU / multiplier
  always_comb begin
    alu_res = '0;
    case (bus.aluop)
      OP_ADD:    alu_res = bus.op1 + bus.op2;
      OP_SUB:    alu_res = bus.op1 - bus.op2;
      OP_SLL:    alu_res = bus.op1 << shamt;
      OP_SLT:    alu_res = XLEN'($signed(bus.op1) < $signed(bus.op2));
      OP_SLTU:   alu_res = XLEN'(bus.op1 < bus.op2);
      OP_XOR:    alu_res = bus.op1 ^ bus.op2;
      OP_SRL:    alu_res = bus.op1 >> shamt;
      OP_SRA:    alu_res = XLEN'($signed(bus.op1) >>> shamt);
      OP_OR:     alu_res = bus.op1 | bus.op2;
      OP_AND:    alu_res = bus.op1 & bus.op2;
      OP_MUL:    alu_res = prod_uu[XLEN-1:0];
      OP_MULH:   alu_res = prod_ss[2*XLEN-1:XLEN];
      OP_MULHSU: alu_res = prod_su[2*XLEN-1:XLEN];
      OP_MULHU:  alu_res = prod_uu[2*XLEN-1:XLEN];
      default:   alu_res = '0;
    endcase
  end

  // Divide decode: codes 16..19, bit0 = unsigned, bit1 = remainder
  assign is_div     = (bus.aluop[4:2] == 3'b100);
  assign div_signed = ~bus.aluop[0];
  assign div_rem    = bus.aluop[1];
  assign div_zero   = (bus.op2 == '0);
  assign div_ovf    = div_signed && (bus.op1 == 32'h8000_0000) && (bus.op2 == 32'hFFFF_FFFF);
  assign op1_abs    = (div_signed && bus.op1[XLEN-1]) ? (XLEN'(0) - bus.op1) : bus.op1;
  assign op2_abs    = (div_signed && bus.op2[XLEN-1]) ? (XLEN'(0) - bus.op2) : bus.op2;

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = div_rem ? bus.op1 : 32'hFFFF_FFFF;
    else if (div_ovf) special_res = div_rem ? 32'h0 : 32'h8000_0000;
  end

  assign rem_shift = {rem_q, dividend_q[XLEN-1]};
  assign trial     = {1'b0, rem_shift} - {2'b00, divisor_q};
  assign div_res   = is_rem_q ? (neg_r_q ? (XLEN'(0) - rem_q)  : rem_q)
                              : (neg_q_q ? (XLEN'(0) - quot_q) : quot_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      is_rem_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      is_rem_q   <= is_rem_d;
    end
  end

  // Divider next-state; flush overrides everything and drops the stall request
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    is_rem_d   = is_rem_q;
    busy_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_div && !div_zero && !div_ovf) begin
          dividend_d = op1_abs;
          divisor_d  = op2_abs;
          quot_d     = '0;
          rem_d      = '0;
          cnt_d      = '0;
          neg_q_d    = div_signed && (bus.op1[XLEN-1] ^ bus.op2[XLEN-1]);
          neg_r_d    = div_signed && bus.op1[XLEN-1];
          is_rem_d   = div_rem;
          busy_req   = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        busy_req   = 1'b1;
        dividend_d = {dividend_q[XLEN-2:0], 1'b0};
        if (!trial[XLEN+1]) begin
          rem_d  = trial[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) state_d = DONE;
      end
      DONE: begin
        if (!bus.stall[3]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      busy_req = 1'b0;
    end
  end

  always_comb begin
    result_c = alu_res;
    if (state_q == DONE) result_c = div_res;
    else if (is_div)     result_c = (div_zero || div_ovf) ? special_res : '0;
  end

  assign bus.stall_req = busy_req & ~rst;
  assign bus.rd_o      = bus.rd;
  assign bus.regwe_o   = bus.regwe & ~bus.stall_req & ~bus.flush;
  assign bus.result    = result_c;

  assign unused_bits = ^{bus.stall[5:4], bus.stall[2:0], prod_ss[XLEN-1:0],
                         prod_su[XLEN-1:0], trial[XLEN]};
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU/multiplier vectors, divider latency,
// special cases, DONE hold, flush and reset aborts.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  ex_if bus();

  ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    bus.aluop = op;
    bus.op1   = a;
    bus.op2   = b;
    #1;
    check({tag, " result"}, bus.result, exp);
    check({tag, " stall_req"}, 32'(bus.stall_req), 32'd0);
    tick;
  endtask

  // Counts consecutive stall_req cycles from the issue cycle, then checks the DONE value
  task automatic run_div(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (bus.stall_req === 1'b1 && n < 100) begin
      n++;
      tick;
    end
    check({tag, " stall cycles"}, 32'(n), 32'd33);
    check({tag, " result"}, bus.result, exp);
    check({tag, " done stall_req"}, 32'(bus.stall_req), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.rd    = 5'd5;
    bus.regwe = 1'b1;
    bus.aluop = 5'd0;
    bus.op1   = 32'd3;
    bus.op2   = 32'd4;
    bus.stall = 6'd0;
    bus.flush = 1'b0;
    #1;
    check("reset stall_req", 32'(bus.stall_req), 32'd0);
    check("reset add", bus.result, 32'd7);
    check("reset rd_o", 32'(bus.rd_o), 32'd5);
    check("reset regwe_o", 32'(bus.regwe_o), 32'd1);
    tick;
    tick;
    rst = 1'b0;

    alu("add ovf", 5'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000);
    alu("sra",     5'd7,  32'h8000_0000, 32'd4,         32'hF800_0000);
    alu("sra op2 hi bits", 5'd7, 32'h8000_0000, 32'h24, 32'hF800_0000);
    alu("srl",     5'd6,  32'h8000_0000, 32'd4,         32'h0800_0000);
    alu("sll",     5'd2,  32'h1,         32'h21,        32'h2);
    alu("sub",     5'd1,  32'd5,         32'd7,         32'hFFFF_FFFE);
    alu("slt",     5'd3,  32'hFFFF_FFFF, 32'd1,         32'd1);
    alu("sltu",    5'd4,  32'hFFFF_FFFF, 32'd1,         32'd0);
    alu("xor",     5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu("or",      5'd8,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    alu("and",     5'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu("mul",     5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    alu("mulh",    5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    alu("mulhsu",  5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    alu("mulhu",   5'd13, 32'h0001_0000, 32'h0003_0000, 32'h3);
    alu("code14",  5'd14, 32'h1234_5678, 32'h1,         32'h0);
    bus.regwe = 1'b0;
    bus.rd    = 5'd17;
    #1;
    check("regwe0 passthru", 32'(bus.regwe_o), 32'd0);
    check("rd_o passthru", 32'(bus.rd_o), 32'd17);
    bus.regwe = 1'b1;
    tick;

    // DIV -7 / 2, then REM of the same operands
    bus.aluop = 5'd16;
    bus.op1   = 32'hFFFF_FFF9;
    bus.op2   = 32'd2;
    #1;
    check("div issue stall_req", 32'(bus.stall_req), 32'd1);
    check("div issue regwe_o", 32'(bus.regwe_o), 32'd0);
    run_div("div -7/2", 32'hFFFF_FFFD);
    check("div done regwe_o", 32'(bus.regwe_o), 32'd1);
    tick;
    bus.aluop = 5'd18;
    #1;
    check("rem issue stall_req", 32'(bus.stall_req), 32'd1);
    run_div("rem -7/2", 32'hFFFF_FFFF);
    tick;

    // Special cases resolve in the issue cycle
    alu("divu by 0", 5'd17, 32'd100,       32'd0,         32'hFFFF_FFFF);
    alu("remu by 0", 5'd19, 32'd100,       32'd0,         32'd100);
    alu("div ovf",   5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    alu("rem ovf",   5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // DIVU held in DONE by stall[3]
    bus.aluop = 5'd17;
    bus.op1   = 32'hFFFF_FFFF;
    bus.op2   = 32'd3;
    #1;
    run_div("divu hold", 32'h5555_5555);
    bus.stall = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold cycle %0d result", i), bus.result, 32'h5555_5555);
      check($sformatf("hold cycle %0d stall_req", i), 32'(bus.stall_req), 32'd0);
      tick;
    end
    bus.stall = 6'd0;
    #1;
    check("hold release result", bus.result, 32'h5555_5555);
    tick;
    alu("idle after hold", 5'd0, 32'd1, 32'd1, 32'd2);

    // Flush at BUSY iteration 10, then DIVU 9/3 from IDLE
    bus.aluop = 5'd17;
    bus.op1   = 32'd1000;
    bus.op2   = 32'd7;
    #1;
    repeat (10) tick;
    check("pre-flush stall_req", 32'(bus.stall_req), 32'd1);
    bus.flush = 1'b1;
    #1;
    check("flush stall_req", 32'(bus.stall_req), 32'd0);
    check("flush regwe_o", 32'(bus.regwe_o), 32'd0);
    tick;
    bus.flush = 1'b0;
    bus.op1   = 32'd9;
    bus.op2   = 32'd3;
    #1;
    check("post-flush issue", 32'(bus.stall_req), 32'd1);
    run_div("divu 9/3", 32'd3);
    tick;

    // Reset at BUSY iteration 20
    bus.aluop = 5'd17;
    bus.op1   = 32'hFFFF_FFFF;
    bus.op2   = 32'd3;
    #1;
    repeat (20) tick;
    check("pre-rst stall_req", 32'(bus.stall_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rst stall_req", 32'(bus.stall_req), 32'd0);
    tick;
    rst = 1'b0;
    alu("mulhu after rst", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
